// File: rtl/qmult_pipe_pkg.sv
// Shared definitions for the pipelined sign-magnitude fixed-point multiplier.
// The rounding-mode encodings apply to the rnd_mode input of qmult_pipe.
package qmult_pipe_pkg;

    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_NEAREST = 1'b1;

endpackage

// File: rtl/qmult_pipe_lane.sv
// One lane of the multiplier. The product half and the round/saturate/sign half
// are separate so the parent can put a pipeline register between them.
module qmult_lane
    import qmult_pipe_pkg::*;
#(
    parameter int N   = 32,
    parameter int Q   = 15,
    parameter int SAT = 1
) (
    input  logic [N-1:0]     i_a,
    input  logic [N-1:0]     i_b,
    output logic [2*N-3:0]   o_prod,
    output logic             o_sign,
    input  logic [2*N-3:0]   i_prod,
    input  logic             i_sign,
    input  logic             i_rnd,
    output logic [N-1:0]     o_c,
    output logic             o_ovf
);
    localparam int PW = 2 * N - 2;

    logic [PW-1:0] w_ma, w_mb;
    logic          w_hi;
    logic          w_rbit;
    logic [N-1:0]  w_sum;
    logic [N-2:0]  w_mag;

    assign w_ma   = {{(N-1){1'b0}}, i_a[N-2:0]};
    assign w_mb   = {{(N-1){1'b0}}, i_b[N-2:0]};
    assign o_prod = w_ma * w_mb;
    assign o_sign = i_a[N-1] ^ i_b[N-1];

    // Overflow comes either from product bits above the result window or from
    // the rounding increment carrying out of the N-1 bit magnitude.
    assign w_hi   = |i_prod[PW-1:N-1+Q];
    assign w_rbit = (i_rnd == RND_NEAREST) & i_prod[Q-1];
    assign w_sum  = {1'b0, i_prod[N-2+Q:Q]} + {{(N-1){1'b0}}, w_rbit};
    assign o_ovf  = w_hi | w_sum[N-1];
    assign w_mag  = (o_ovf && SAT != 0) ? '1 : w_sum[N-2:0];

    assign o_c = {i_sign & (|w_mag), w_mag};

endmodule

// File: rtl/qmult_pipe.sv
// Multi-lane pipelined Qm.Q multiplier with a single valid/ready handshake.
// Stage 1 holds raw products, middle stages are delay, the last stage holds results.
module qmult_pipe
    import qmult_pipe_pkg::*;
#(
    parameter int N      = 32,
    parameter int Q      = 15,
    parameter int LANES  = 1,
    parameter int STAGES = 2,
    parameter int SAT    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               rnd_mode,
    input  logic [LANES*N-1:0] a,
    input  logic [LANES*N-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] c,
    output logic [LANES-1:0]   ovf
);
    localparam int PW  = 2 * N - 2;
    localparam int MID = (STAGES > 1) ? STAGES - 1 : 1;

    logic                     w_en;
    logic [STAGES-1:0]        r_vld;
    logic [LANES-1:0][PW-1:0] w_prod, w_pprod;
    logic [LANES-1:0]         w_sgn, w_psgn, w_ovf;
    logic                     w_prnd;
    logic [LANES*N-1:0]       w_c, r_c;
    logic [LANES-1:0]         r_ovf;

    // Whole pipe moves in lockstep; a held output freezes every stage.
    assign w_en      = !r_vld[STAGES-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld[STAGES-1];
    assign c         = r_c;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    generate
        if (STAGES > 1) begin : g_mid
            logic [MID-1:0][LANES-1:0][PW-1:0] r_prod;
            logic [MID-1:0][LANES-1:0]         r_sgn;
            logic [MID-1:0]                    r_rnd;

            always_ff @(posedge clk) begin
                if (w_en) begin
                    r_prod[0] <= w_prod;
                    r_sgn[0]  <= w_sgn;
                    r_rnd[0]  <= rnd_mode;
                    for (int i = 1; i < MID; i++) begin
                        r_prod[i] <= r_prod[i-1];
                        r_sgn[i]  <= r_sgn[i-1];
                        r_rnd[i]  <= r_rnd[i-1];
                    end
                end
            end

            assign w_pprod = r_prod[MID-1];
            assign w_psgn  = r_sgn[MID-1];
            assign w_prnd  = r_rnd[MID-1];
        end else begin : g_comb
            // Single stage: product and post-processing share one register.
            assign w_pprod = w_prod;
            assign w_psgn  = w_sgn;
            assign w_prnd  = rnd_mode;
        end
    endgenerate

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        qmult_lane #(.N(N), .Q(Q), .SAT(SAT)) u_lane (
            .i_a    (a[k*N +: N]),
            .i_b    (b[k*N +: N]),
            .o_prod (w_prod[k]),
            .o_sign (w_sgn[k]),
            .i_prod (w_pprod[k]),
            .i_sign (w_psgn[k]),
            .i_rnd  (w_prnd),
            .o_c    (w_c[k*N +: N]),
            .o_ovf  (w_ovf[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c   <= '0;
            r_ovf <= '0;
        end else if (w_en) begin
            r_c   <= w_c;
            r_ovf <= w_ovf;
        end
    end

endmodule
